// File: rtl/vram_writer.sv
// vram_writer: host-side text-mode character writer.
// Buffers host DATA writes in a 4-entry FIFO and drains them into the
// character RAM only while the display is blanked. A CLEAR sweep fills the
// 80x60 text page with spaces, also only during blanking.
module vram_writer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic [1:0]  reg_sel,
    input  logic [7:0]  data_in,
    input  logic        visible,
    output logic        vram_we,
    output logic [12:0] vram_addr,
    output logic [7:0]  vram_data,
    output logic [3:0]  status
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t      state;

    // host cursor
    logic [6:0]  cur_col;
    logic [5:0]  cur_row;

    // FIFO entry layout: {row[5:0], col[6:0], char[7:0]}
    logic [20:0] fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic        overflow;

    // clear sweep counter
    logic [6:0]  clr_col;
    logic [5:0]  clr_row;

    logic        fifo_empty;
    logic        fifo_full;
    logic        host_data;
    logic        host_ctrl;
    logic        push;
    logic        pop;
    logic        clr_wr;
    logic [20:0] head;

    // Host decode, FIFO handshake and the write port; vram_we must follow
    // visible in the same cycle, so the write port is combinational.
    always_comb begin
        fifo_empty = (count == 3'd0);
        fifo_full  = (count == 3'd4);
        host_data  = cs && (reg_sel == 2'd0);
        host_ctrl  = cs && (reg_sel == 2'd3);
        push       = host_data && !fifo_full;
        pop        = (state == IDLE) && !visible && !fifo_empty;
        clr_wr     = (state == CLEAR) && !visible;
        head       = fifo_mem[rd_ptr];

        vram_we    = 1'b0;
        vram_addr  = '0;
        vram_data  = '0;
        if (pop) begin
            vram_we   = 1'b1;
            vram_addr = head[20:8];
            vram_data = head[7:0];
        end else if (clr_wr) begin
            vram_we   = 1'b1;
            vram_addr = {clr_row, clr_col};
            vram_data = 8'h20;
        end

        status = {(state == CLEAR), overflow, fifo_full, fifo_empty};
    end

    // Cursor: COL/ROW loads with range check; every DATA write advances it,
    // whether or not the FIFO accepted the entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_col <= '0;
            cur_row <= '0;
        end else if (cs) begin
            case (reg_sel)
                2'd0: begin
                    if (cur_col == 7'd79) begin
                        cur_col <= '0;
                        cur_row <= (cur_row == 6'd59) ? 6'd0 : cur_row + 6'd1;
                    end else begin
                        cur_col <= cur_col + 7'd1;
                    end
                end
                2'd1: if (data_in[6:0] < 7'd80) cur_col <= data_in[6:0];
                2'd2: if (data_in[5:0] < 6'd60) cur_row <= data_in[5:0];
                default: ;
            endcase
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {cur_row, cur_col, data_in};
    end

    // FIFO pointers, occupancy and sticky overflow. A drop in the same
    // cycle as a clear request keeps overflow set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: ;
            endcase
            if (host_data && fifo_full)
                overflow <= 1'b1;
            else if (host_ctrl && data_in[0])
                overflow <= 1'b0;
        end
    end

    // IDLE/CLEAR state machine with the row-major clear sweep counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            clr_col <= '0;
            clr_row <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (host_ctrl && data_in[1]) begin
                        state   <= CLEAR;
                        clr_col <= '0;
                        clr_row <= '0;
                    end
                end
                CLEAR: begin
                    if (!visible) begin
                        if (clr_col == 7'd79) begin
                            clr_col <= '0;
                            if (clr_row == 6'd59) begin
                                clr_row <= '0;
                                state   <= IDLE;
                            end else begin
                                clr_row <= clr_row + 6'd1;
                            end
                        end else begin
                            clr_col <= clr_col + 7'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_writer.sv
// tb_vram_writer: scoreboard bench for vram_writer. Expected VRAM writes are
// queued as stimulus is driven and compared in order as the DUT writes.
module tb_vram_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs;
    logic [1:0]  reg_sel;
    logic [7:0]  data_in;
    logic        visible;
    logic        vram_we;
    logic [12:0] vram_addr;
    logic [7:0]  vram_data;
    logic [3:0]  status;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [20:0] sb [$];
    logic [5:0]  mrow;
    logic [6:0]  mcol;
    logic        mon_en = 1'b0;
    logic        tog_en = 1'b0;

    vram_writer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (cs),
        .reg_sel   (reg_sel),
        .data_in   (data_in),
        .visible   (visible),
        .vram_we   (vram_we),
        .vram_addr (vram_addr),
        .vram_data (vram_data),
        .status    (status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input logic [1:0] sel, input logic [7:0] d);
        cs      = 1'b1;
        reg_sel = sel;
        data_in = d;
        step();
        cs      = 1'b0;
    endtask

    task automatic set_col(input logic [7:0] d);
        host_wr(2'd1, d);
        if (d[6:0] < 7'd80) mcol = d[6:0];
    endtask

    task automatic set_row(input logic [7:0] d);
        host_wr(2'd2, d);
        if (d[5:0] < 6'd60) mrow = d[5:0];
    endtask

    task automatic model_adv();
        if (mcol == 7'd79) begin
            mcol = '0;
            mrow = (mrow == 6'd59) ? 6'd0 : mrow + 6'd1;
        end else begin
            mcol = mcol + 7'd1;
        end
    endtask

    task automatic put(input logic [7:0] d, input bit accept);
        if (accept) sb.push_back({mrow, mcol, d});
        host_wr(2'd0, d);
        model_adv();
    endtask

    task automatic push_clear();
        for (int r = 0; r < 60; r++)
            for (int c = 0; c < 80; c++)
                sb.push_back({6'(r), 7'(c), 8'h20});
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    // Output monitor: in-order compare of every write against the scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            logic [20:0] exp;
            if (visible) check("we_while_visible", 32'(vram_we), 32'd0);
            if (vram_we === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", 32'(vram_we), 32'd0);
                end else begin
                    exp = sb.pop_front();
                    check("wr_addr", 32'(vram_addr), 32'(exp[20:8]));
                    check("wr_data", 32'(vram_data), 32'(exp[7:0]));
                end
            end else begin
                check("idle_addr", 32'(vram_addr), 32'd0);
                check("idle_data", 32'(vram_data), 32'd0);
            end
        end
    end

    // Blanking pattern for the clear sweep: 100 cycles low, 100 high
    initial begin
        forever begin
            wait (tog_en);
            repeat (100) step();
            visible = 1'b1;
            repeat (100) step();
            visible = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        // reset with cs active: the DATA strobes must be ignored
        rst_n   = 1'b0;
        cs      = 1'b1;
        reg_sel = 2'd0;
        data_in = 8'h99;
        visible = 1'b0;
        mrow    = '0;
        mcol    = '0;
        repeat (3) step();
        rst_n  = 1'b1;
        cs     = 1'b0;
        mon_en = 1'b1;
        check("rst_we", 32'(vram_we), 32'd0);
        check("rst_status", 32'(status), 32'h1);

        // cursor starts at (0,0) and nothing was queued during reset
        put(8'h30, 1'b1);
        wait_drain(10, "drain_rst");

        // basic positioned write, then cursor advance
        set_row(8'd5);
        set_col(8'd10);
        put(8'h41, 1'b1);
        put(8'h42, 1'b1);
        wait_drain(10, "drain_basic");

        // out-of-range loads are ignored; high bit of COL is outside the field
        set_col(8'd80);
        set_row(8'd60);
        put(8'h50, 1'b1);
        set_col(8'h85);
        set_row(8'h47);
        put(8'h51, 1'b1);
        wait_drain(10, "drain_range");

        // wrap at the last cell while blanking is off
        visible = 1'b1;
        set_col(8'd79);
        set_row(8'd59);
        put(8'h42, 1'b1);
        put(8'h43, 1'b1);
        repeat (5) step();
        check("hold_status", 32'(status), 32'h0);
        visible = 1'b0;
        wait_drain(10, "drain_wrap");
        put(8'h44, 1'b1);
        wait_drain(10, "drain_wrap2");

        // FIFO full, drop and sticky overflow
        set_row(8'd10);
        set_col(8'd0);
        visible = 1'b1;
        for (int i = 0; i < 4; i++) put(8'h60 + 8'(i), 1'b1);
        check("full_status", 32'(status), 32'h2);
        put(8'h64, 1'b0);
        check("ovf_status", 32'(status), 32'h6);
        host_wr(2'd3, 8'h01);
        check("ovf_clr_status", 32'(status), 32'h2);
        visible = 1'b0;
        wait_drain(10, "drain_full");
        check("empty_status", 32'(status), 32'h1);
        put(8'h65, 1'b1);
        put(8'h66, 1'b1);
        put(8'h67, 1'b1);
        wait_drain(10, "drain_stream");

        // full-page clear with host data queued during the sweep
        set_row(8'd0);
        set_col(8'd0);
        push_clear();
        host_wr(2'd3, 8'h02);
        tog_en = 1'b1;
        check("clr_status", 32'(status), 32'h9);
        put(8'h55, 1'b1);
        host_wr(2'd3, 8'h02);
        n = 0;
        while (status[3] && n < 12000) begin
            step();
            n++;
        end
        check("clear_done", 32'(status[3]), 32'd0);
        check("clear_left", 32'(sb.size()), 32'd1);
        tog_en = 1'b0;
        repeat (210) step();
        check("drain_55", 32'(sb.size()), 32'd0);
        put(8'h56, 1'b1);
        wait_drain(10, "drain_after_clr");

        // reset midway through a clear, with a pending FIFO entry
        visible = 1'b0;
        push_clear();
        host_wr(2'd3, 8'h02);
        repeat (50) step();
        put(8'h77, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        sb.delete();
        mrow = '0;
        mcol = '0;
        check("abort_we", 32'(vram_we), 32'd0);
        check("abort_status", 32'(status), 32'h1);
        repeat (100) step();
        put(8'h11, 1'b1);
        wait_drain(10, "drain_post_abort");
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
